// File: rtl/ni_apb_requester.sv
// Initiator-side network interface: an APB completer that turns each transfer into
// a one-cycle request packet for the local router and completes on the matching response.

package pa_noc;
    localparam int APB_PACKET_WIDTH = 59;
endpackage

module ni_apb_requester
    import pa_noc::*;
#(
    parameter int NODE_ROW = 0,
    parameter int NODE_COL = 0,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic                        i_clk,
    input  logic                        i_srst,
    input  logic                        i_psel,
    input  logic                        i_penable,
    input  logic                        i_pwrite,
    input  logic [ADDR_W-1:0]           i_paddr,
    input  logic [DATA_W-1:0]           i_pwdata,
    output logic [DATA_W-1:0]           o_prdata,
    output logic                        o_pready,
    output logic                        o_pslverr,
    output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
    input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket
);

    localparam int PW       = APB_PACKET_WIDTH;
    localparam int VALID    = PW - 1;
    localparam int KIND     = PW - 2;
    localparam int WRITE    = PW - 3;
    localparam int ADDR_LSB = 8;
    localparam int DATA_LSB = ADDR_W + 8;
    localparam int TW       = $clog2(TIMEOUT);

    localparam logic [1:0] OWN_ROW = 2'(NODE_ROW);
    localparam logic [1:0] OWN_COL = 2'(NODE_COL);

    generate
        if (PW != DATA_W + ADDR_W + 11) begin : g_widthCheck
            $error("APB_PACKET_WIDTH must equal DATA_W + ADDR_W + 11");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic                wrReg;
    logic                errReg;
    logic [ADDR_W-1:0]   addrReg;
    logic [DATA_W-1:0]   wdataReg;

    logic                rspHit;
    logic [DATA_W-1:0]   rspData;
    logic [DATA_W-1:0]   reqData;
    logic                unusedRspBits;

    // The response must come back from the node we addressed and be aimed at us.
    assign rspHit  = i_apbPacket[VALID] && i_apbPacket[KIND]
                  && (i_apbPacket[3:0] == {OWN_ROW, OWN_COL})
                  && (i_apbPacket[7:4] == addrReg[ADDR_W-1 -: 4]);
    assign rspData = i_apbPacket[DATA_LSB +: DATA_W];
    assign reqData = wdataReg & {DATA_W{wrReg}};

    assign unusedRspBits = ^{i_apbPacket[WRITE], i_apbPacket[ADDR_LSB +: ADDR_W]};

    // Pulse outputs default low each cycle; only SEND and RESP raise them.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state       <= IDLE;
            timer       <= '0;
            wrReg       <= 1'b0;
            errReg      <= 1'b0;
            addrReg     <= '0;
            wdataReg    <= '0;
            o_apbPacket <= '0;
            o_pready    <= 1'b0;
            o_pslverr   <= 1'b0;
            o_prdata    <= '0;
        end else begin
            o_apbPacket <= '0;
            o_pready    <= 1'b0;
            o_pslverr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_psel && !i_penable) begin
                        wrReg    <= i_pwrite;
                        addrReg  <= i_paddr;
                        wdataReg <= i_pwdata;
                        if (i_paddr[ADDR_W-1 -: 4] == {OWN_ROW, OWN_COL}) begin
                            errReg   <= 1'b1;
                            o_prdata <= '0;
                            state    <= RESP;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    o_apbPacket <= {1'b1, 1'b0, wrReg, reqData, addrReg,
                                    OWN_ROW, OWN_COL, addrReg[ADDR_W-1 -: 4]};
                    timer       <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // A response arriving on the last timer cycle still wins.
                    if (rspHit) begin
                        o_prdata <= wrReg ? {DATA_W{1'b0}} : rspData;
                        errReg   <= 1'b0;
                        state    <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        o_prdata <= '0;
                        errReg   <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    o_pready  <= 1'b1;
                    o_pslverr <= errReg;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_apb_requester.sv
// Scoreboard bench for ni_apb_requester: stimulus pushes expected packets/completions
// with their cycle stamps, negedge monitors pop and compare whatever the DUTs present.

module tb_ni_apb_requester;
    import pa_noc::*;

    localparam int PW = APB_PACKET_WIDTH;
    localparam int TO = 16;

    typedef struct {
        int            cyc;
        logic [PW-1:0] pkt;
    } pktExp_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
        bit          chkData;
    } rspExp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst;
    logic          pselA, penableA, pwriteA, preadyA, pslverrA;
    logic [15:0]   paddrA;
    logic [31:0]   pwdataA, prdataA;
    logic [PW-1:0] pktOutA, pktInA;
    logic          pselB, penableB, pwriteB, preadyB, pslverrB;
    logic [15:0]   paddrB;
    logic [31:0]   pwdataB, prdataB;
    logic [PW-1:0] pktOutB, pktInB;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit monOn = 1'b0;

    pktExp_t pktQA[$];
    rspExp_t rspQA[$];
    rspExp_t rspQB[$];

    localparam logic [PW-1:0] REQ1   = {3'b101, 32'hCAFEF00D, 16'h9034, 4'h0, 4'h9};
    localparam logic [PW-1:0] RSP1   = {3'b111, 32'h5555AAAA, 16'h9034, 4'h9, 4'h0};
    localparam logic [PW-1:0] REQ2   = {3'b100, 32'h00000000, 16'h7010, 4'h0, 4'h7};
    localparam logic [PW-1:0] RSP2   = {3'b110, 32'hDEADBEEF, 16'h7010, 4'h7, 4'h0};
    localparam logic [PW-1:0] REQ3   = {3'b100, 32'h00000000, 16'hF000, 4'h0, 4'hF};
    localparam logic [PW-1:0] REQ5   = {3'b100, 32'h00000000, 16'h6000, 4'h0, 4'h6};
    localparam logic [PW-1:0] BADSRC = {3'b110, 32'h11111111, 16'h6000, 4'h1, 4'h0};
    localparam logic [PW-1:0] BADKND = {3'b100, 32'h22222222, 16'h6000, 4'h6, 4'h0};
    localparam logic [PW-1:0] RSP5   = {3'b110, 32'h33333333, 16'h6000, 4'h6, 4'h0};

    ni_apb_requester #(.NODE_ROW(0), .NODE_COL(0), .ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dutA (
        .i_clk(clk), .i_srst(srst), .i_psel(pselA), .i_penable(penableA), .i_pwrite(pwriteA),
        .i_paddr(paddrA), .i_pwdata(pwdataA), .o_prdata(prdataA), .o_pready(preadyA),
        .o_pslverr(pslverrA), .o_apbPacket(pktOutA), .i_apbPacket(pktInA)
    );

    ni_apb_requester #(.NODE_ROW(2), .NODE_COL(2), .ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dutB (
        .i_clk(clk), .i_srst(srst), .i_psel(pselB), .i_penable(penableB), .i_pwrite(pwriteB),
        .i_paddr(paddrB), .i_pwdata(pwdataB), .o_prdata(prdataB), .o_pready(preadyB),
        .o_pslverr(pslverrB), .o_apbPacket(pktOutB), .i_apbPacket(pktInB)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flagUnexpected(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("[TB] FAIL %s: got unexpected %0h, required nothing (cycle %0d)", nm, act, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectPkt(input int c, input logic [PW-1:0] p);
        pktExp_t e;
        e.cyc = c;
        e.pkt = p;
        pktQA.push_back(e);
    endtask

    task automatic expectRsp(input bit useB, input int c, input logic err,
                             input logic [31:0] d, input bit chk);
        rspExp_t e;
        e.cyc = c;
        e.err = err;
        e.data = d;
        e.chkData = chk;
        if (useB) rspQB.push_back(e);
        else rspQA.push_back(e);
    endtask

    // Drives the setup phase in the current cycle, then the access phase.
    task automatic applyStimulus(input bit useB, input logic wr, input logic [15:0] addr,
                                 input logic [31:0] wd, output int s);
        s = cyc;
        if (useB) begin
            pselB = 1'b1; penableB = 1'b0; pwriteB = wr; paddrB = addr; pwdataB = wd;
        end else begin
            pselA = 1'b1; penableA = 1'b0; pwriteA = wr; paddrA = addr; pwdataA = wd;
        end
        tick();
        if (useB) penableB = 1'b1;
        else penableA = 1'b1;
    endtask

    task automatic finishXfer(input bit useB, input string nm);
        int n;
        n = 0;
        while (!(useB ? preadyB : preadyA) && n < TO + 20) begin
            tick();
            n++;
        end
        total++;
        if (!(useB ? preadyB : preadyA)) begin
            bad++;
            $display("[TB] FAIL %s: got no pready after %0d cycles, required completion", nm, n);
        end else begin
            tick();
        end
        if (useB) begin
            pselB = 1'b0; penableB = 1'b0;
        end else begin
            pselA = 1'b0; penableA = 1'b0;
        end
        tick();
    endtask

    task automatic runWrite1(input string nm);
        int s;
        applyStimulus(1'b0, 1'b1, 16'h9034, 32'hCAFEF00D, s);
        expectPkt(s + 2, REQ1);
        tick();
        pktInA = RSP1;
        expectRsp(1'b0, s + 4, 1'b0, 32'h0, 1'b1);
        tick();
        pktInA = '0;
        finishXfer(1'b0, nm);
    endtask

    always @(negedge clk) begin : monA
        pktExp_t pe;
        rspExp_t re;
        if (monOn) begin
            if (pktOutA !== '0) begin
                if (pktQA.size() == 0) flagUnexpected("pktA", 64'(pktOutA));
                else begin
                    pe = pktQA.pop_front();
                    checkOutput("pktA", 64'(pktOutA), 64'(pe.pkt));
                    checkOutput("pktCycA", 64'(cyc), 64'(pe.cyc));
                end
            end
            if (preadyA) begin
                if (rspQA.size() == 0) flagUnexpected("preadyA", 64'(preadyA));
                else begin
                    re = rspQA.pop_front();
                    checkOutput("pslverrA", 64'(pslverrA), 64'(re.err));
                    checkOutput("rspCycA", 64'(cyc), 64'(re.cyc));
                    if (re.chkData) checkOutput("prdataA", 64'(prdataA), 64'(re.data));
                end
            end
        end
    end

    always @(negedge clk) begin : monB
        rspExp_t re;
        if (monOn) begin
            if (pktOutB !== '0) flagUnexpected("pktB", 64'(pktOutB));
            if (preadyB) begin
                if (rspQB.size() == 0) flagUnexpected("preadyB", 64'(preadyB));
                else begin
                    re = rspQB.pop_front();
                    checkOutput("pslverrB", 64'(pslverrB), 64'(re.err));
                    checkOutput("rspCycB", 64'(cyc), 64'(re.cyc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int p;
        srst = 1'b1;
        pselA = 1'b0; penableA = 1'b0; pwriteA = 1'b0; paddrA = '0; pwdataA = '0; pktInA = '0;
        pselB = 1'b0; penableB = 1'b0; pwriteB = 1'b0; paddrB = '0; pwdataB = '0; pktInB = '0;
        tick(3);
        checkOutput("rstPktA", 64'(pktOutA), 64'h0);
        checkOutput("rstReadyA", 64'(preadyA), 64'h0);
        checkOutput("rstErrA", 64'(pslverrA), 64'h0);
        checkOutput("rstRdataA", 64'(prdataA), 64'h0);
        checkOutput("rstReadyB", 64'(preadyB), 64'h0);
        srst = 1'b0;
        monOn = 1'b1;
        tick();

        $display("[TB] write to (2,1) with minimum-latency response");
        runWrite1("write1");

        $display("[TB] stray response while idle is dropped");
        pktInA = RSP2;
        tick();
        pktInA = '0;
        tick(2);

        $display("[TB] read from (1,3), response three cycles after the request");
        applyStimulus(1'b0, 1'b0, 16'h7010, 32'hFFFFFFFF, s);
        p = s + 2;
        expectPkt(p, REQ2);
        tick(4);
        pktInA = RSP2;
        expectRsp(1'b0, p + 5, 1'b0, 32'hDEADBEEF, 1'b1);
        tick();
        pktInA = '0;
        finishXfer(1'b0, "read2");

        $display("[TB] read from (3,3) with no response times out");
        applyStimulus(1'b0, 1'b0, 16'hF000, 32'h0, s);
        expectPkt(s + 2, REQ3);
        expectRsp(1'b0, s + 2 + TO + 1, 1'b1, 32'h0, 1'b1);
        finishXfer(1'b0, "timeout3");

        $display("[TB] self-addressed transfers complete with an error");
        applyStimulus(1'b1, 1'b1, 16'hA123, 32'h12345678, s);
        expectRsp(1'b1, s + 2, 1'b1, 32'h0, 1'b0);
        finishXfer(1'b1, "selfB");
        applyStimulus(1'b0, 1'b1, 16'h0ABC, 32'h87654321, s);
        expectRsp(1'b0, s + 2, 1'b1, 32'h0, 1'b0);
        finishXfer(1'b0, "selfA");

        $display("[TB] wrong-source and request-kind packets are ignored in WAIT");
        applyStimulus(1'b0, 1'b0, 16'h6000, 32'h0, s);
        p = s + 2;
        expectPkt(p, REQ5);
        tick();
        pktInA = BADSRC;
        tick();
        pktInA = BADKND;
        tick();
        pktInA = RSP5;
        expectRsp(1'b0, p + 4, 1'b0, 32'h33333333, 1'b1);
        tick();
        pktInA = '0;
        finishXfer(1'b0, "filter5");

        $display("[TB] reset during WAIT abandons the transfer");
        applyStimulus(1'b0, 1'b1, 16'h9034, 32'hCAFEF00D, s);
        expectPkt(s + 2, REQ1);
        tick(2);
        srst = 1'b1;
        pselA = 1'b0;
        penableA = 1'b0;
        tick();
        srst = 1'b0;
        checkOutput("midRstPktA", 64'(pktOutA), 64'h0);
        checkOutput("midRstReadyA", 64'(preadyA), 64'h0);
        checkOutput("midRstErrA", 64'(pslverrA), 64'h0);
        checkOutput("midRstRdataA", 64'(prdataA), 64'h0);
        tick();
        pktInA = RSP1;
        tick();
        pktInA = '0;
        tick(3);
        runWrite1("write1AfterReset");

        tick(5);
        checkOutput("leftPktQA", 64'(pktQA.size()), 64'h0);
        checkOutput("leftRspQA", 64'(rspQA.size()), 64'h0);
        checkOutput("leftRspQB", 64'(rspQB.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
